// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath and the stall/flush controller.
// master = pipeline side (drives operand/producer info), slave = controller.
interface pipeline_hazard_ctrl_if #(
    parameter int CNT_W  = 4,
    parameter int PERF_W = 32
);
    logic [4:0]        D_rs;
    logic [4:0]        D_rt;
    logic [1:0]        D_tuse_rs;
    logic [1:0]        D_tuse_rt;
    logic              D_is_md;
    logic [4:0]        E_wa;
    logic [1:0]        E_tnew;
    logic              E_md_start;
    logic              E_md_is_div;
    logic [4:0]        M_wa;
    logic [1:0]        M_tnew;
    logic              F_pc_en;
    logic              D_reg_en;
    logic              E_reg_flush;
    logic              md_busy;
    logic [CNT_W-1:0]  md_cnt;
    logic [PERF_W-1:0] stall_cycles;

    modport master (
        output D_rs, D_rt, D_tuse_rs, D_tuse_rt, D_is_md,
        output E_wa, E_tnew, E_md_start, E_md_is_div,
        output M_wa, M_tnew,
        input  F_pc_en, D_reg_en, E_reg_flush,
        input  md_busy, md_cnt, stall_cycles
    );

    modport slave (
        input  D_rs, D_rt, D_tuse_rs, D_tuse_rt, D_is_md,
        input  E_wa, E_tnew, E_md_start, E_md_is_div,
        input  M_wa, M_tnew,
        output F_pc_en, D_reg_en, E_reg_flush,
        output md_busy, md_cnt, stall_cycles
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for the 5-stage MIPS pipeline: Tuse/Tnew data
// hazards, mult/div busy tracking and a saturating stall-cycle counter.
module pipeline_hazard_ctrl #(
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10,
    parameter int CNT_W    = 4,
    parameter int PERF_W   = 32
) (
    input  logic clk,
    input  logic reset,
    pipeline_hazard_ctrl_if.slave hz
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } md_state_t;

    localparam logic [CNT_W-1:0] MULT_CNT = CNT_W'(MULT_LAT);
    localparam logic [CNT_W-1:0] DIV_CNT  = CNT_W'(DIV_LAT);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    md_state_t         state;
    md_state_t         state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_nxt;
    logic [CNT_W-1:0]  load_cnt;
    logic [PERF_W-1:0] perf;
    logic              stall_rs;
    logic              stall_rt;
    logic              stall_md;
    logic              busy;
    logic              stall;

    assign load_cnt = hz.E_md_is_div ? DIV_CNT : MULT_CNT;

    // md FSM state and remaining-cycle register; reset clears both at once
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // md FSM next state: a new start always (re)loads the latency
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        unique case (state)
            IDLE: begin
                if (hz.E_md_start) begin
                    state_nxt = BUSY;
                    cnt_nxt   = load_cnt;
                end
            end
            BUSY: begin
                if (hz.E_md_start) begin
                    cnt_nxt = load_cnt;
                end else if (cnt == CNT_ONE) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt - CNT_ONE;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // hazard detection and pipeline control outputs, forced benign in reset
    always_comb begin
        stall_rs = (hz.D_rs != 5'd0) && (hz.D_tuse_rs != 2'd3) &&
                   (((hz.D_rs == hz.E_wa) && (hz.E_tnew > hz.D_tuse_rs)) ||
                    ((hz.D_rs == hz.M_wa) && (hz.M_tnew > hz.D_tuse_rs)));
        stall_rt = (hz.D_rt != 5'd0) && (hz.D_tuse_rt != 2'd3) &&
                   (((hz.D_rt == hz.E_wa) && (hz.E_tnew > hz.D_tuse_rt)) ||
                    ((hz.D_rt == hz.M_wa) && (hz.M_tnew > hz.D_tuse_rt)));
        busy     = !reset && (hz.E_md_start || (state == BUSY));
        stall_md = hz.D_is_md && busy;
        stall    = !reset && (stall_rs || stall_rt || stall_md);
        hz.F_pc_en     = !stall;
        hz.D_reg_en    = !stall;
        hz.E_reg_flush = stall;
        hz.md_busy     = busy;
    end

    // saturating count of cycles spent stalled
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf <= '0;
        end else if (stall && (perf != '1)) begin
            perf <= perf + PERF_W'(1);
        end
    end

    assign hz.md_cnt       = cnt;
    assign hz.stall_cycles = perf;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: directed vectors push expected
// outputs, a negedge monitor pops and compares.
module tb_pipeline_hazard_ctrl;

    localparam int CNT_W  = 4;
    localparam int PERF_W = 5;
    localparam logic [PERF_W-1:0] SC_MAX = '1;

    typedef struct {
        string             name;
        logic              pc_en;
        logic              d_en;
        logic              flush;
        logic              busy;
        logic [CNT_W-1:0]  cnt;
        logic [PERF_W-1:0] sc;
    } exp_t;

    logic clk;
    logic reset;
    exp_t q[$];
    int   checks;
    int   errors;
    logic [PERF_W-1:0] sc_exp;

    pipeline_hazard_ctrl_if #(.CNT_W(CNT_W), .PERF_W(PERF_W)) hz ();

    pipeline_hazard_ctrl #(
        .MULT_LAT(5),
        .DIV_LAT(10),
        .CNT_W(CNT_W),
        .PERF_W(PERF_W)
    ) dut (
        .clk(clk),
        .reset(reset),
        .hz(hz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input string fld,
                       input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s.%s: got %0d expected %0d", name, fld, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk(e.name, "F_pc_en", int'(hz.F_pc_en), int'(e.pc_en));
            chk(e.name, "D_reg_en", int'(hz.D_reg_en), int'(e.d_en));
            chk(e.name, "E_reg_flush", int'(hz.E_reg_flush), int'(e.flush));
            chk(e.name, "md_busy", int'(hz.md_busy), int'(e.busy));
            chk(e.name, "md_cnt", int'(hz.md_cnt), int'(e.cnt));
            chk(e.name, "stall_cycles", int'(hz.stall_cycles), int'(e.sc));
        end
    end

    // one cycle: drive inputs after posedge, push hand-computed expectation
    task automatic step(input string name, input logic rst,
                        input int rs, input int tur, input int rt, input int tut,
                        input logic ismd, input int ewa, input int etn,
                        input logic mds, input logic mdiv,
                        input int mwa, input int mtn,
                        input logic e_stall, input logic e_busy, input int e_cnt);
        exp_t e;
        @(posedge clk);
        #1;
        reset          = rst;
        hz.D_rs        = 5'(rs);
        hz.D_tuse_rs   = 2'(tur);
        hz.D_rt        = 5'(rt);
        hz.D_tuse_rt   = 2'(tut);
        hz.D_is_md     = ismd;
        hz.E_wa        = 5'(ewa);
        hz.E_tnew      = 2'(etn);
        hz.E_md_start  = mds;
        hz.E_md_is_div = mdiv;
        hz.M_wa        = 5'(mwa);
        hz.M_tnew      = 2'(mtn);
        if (rst) sc_exp = '0;
        e.name  = name;
        e.pc_en = !e_stall;
        e.d_en  = !e_stall;
        e.flush = e_stall;
        e.busy  = e_busy;
        e.cnt   = CNT_W'(e_cnt);
        e.sc    = sc_exp;
        q.push_back(e);
        if (e_stall && sc_exp != SC_MAX) sc_exp = sc_exp + 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        checks = 0;
        errors = 0;
        sc_exp = '0;
        reset  = 1'b1;
        hz.D_rs = '0; hz.D_tuse_rs = 2'd3; hz.D_rt = '0; hz.D_tuse_rt = 2'd3;
        hz.D_is_md = 1'b0; hz.E_wa = '0; hz.E_tnew = '0;
        hz.E_md_start = 1'b0; hz.E_md_is_div = 1'b0;
        hz.M_wa = '0; hz.M_tnew = '0;

        // reset forces benign outputs even with hazards present
        step("rst_force", 1, 1,1, 2,3, 1, 1,2, 1,1, 0,0, 0,0,0);
        step("lw_e_add",  0, 1,1, 2,3, 0, 1,2, 0,0, 0,0, 1,0,0);
        step("lw_m_add",  0, 1,1, 2,3, 0, 0,0, 0,0, 1,1, 0,0,0);
        step("lw_m_beq",  0, 1,0, 2,3, 0, 0,0, 0,0, 1,1, 1,0,0);
        step("r0_nostl",  0, 0,0, 0,3, 0, 0,2, 0,0, 0,0, 0,0,0);
        step("rs_unused", 0, 5,3, 0,3, 0, 5,2, 0,0, 0,0, 0,0,0);
        step("rt_m_haz",  0, 0,3, 7,0, 0, 0,0, 0,0, 7,1, 1,0,0);
        step("e_tnew_eq", 0, 3,1, 0,3, 0, 3,1, 0,0, 0,0, 0,0,0);
        step("rt_tuse_eq",0, 0,3, 9,2, 0, 9,2, 0,0, 0,0, 0,0,0);

        // div: busy 10 cycles after start, D md ops stall each of them
        step("div_start", 0, 0,3, 0,3, 0, 0,0, 1,1, 0,0, 0,1,0);
        for (int i = 0; i < 10; i++)
            step("div_busy", 0, 0,3, 0,3, 1, 0,0, 0,0, 0,0, 1,1,10-i);
        step("div_done",  0, 0,3, 0,3, 1, 0,0, 0,0, 0,0, 0,0,0);

        // mult: start cycle itself already counts as busy
        step("mul_start", 0, 0,3, 0,3, 1, 0,0, 1,0, 0,0, 1,1,0);
        for (int i = 0; i < 5; i++)
            step("mul_busy", 0, 0,3, 0,3, 0, 0,0, 0,0, 0,0, 0,1,5-i);
        step("mul_done",  0, 0,3, 0,3, 0, 0,0, 0,0, 0,0, 0,0,0);

        // hold a data stall long enough to saturate the 5-bit counter
        for (int i = 0; i < 20; i++)
            step("sat_hold", 0, 1,1, 0,3, 0, 1,2, 0,0, 0,0, 1,0,0);
        step("sat_after", 0, 0,3, 0,3, 0, 0,0, 0,0, 0,0, 0,0,0);

        // mult then div restart two cycles later, then async reset mid-busy
        step("rs_mul",    0, 0,3, 0,3, 0, 0,0, 1,0, 0,0, 0,1,0);
        step("rs_m5",     0, 0,3, 0,3, 0, 0,0, 0,0, 0,0, 0,1,5);
        step("rs_div",    0, 0,3, 0,3, 0, 0,0, 1,1, 0,0, 0,1,4);
        step("rs_reload", 0, 0,3, 0,3, 0, 0,0, 0,0, 0,0, 0,1,10);
        step("rs_d9",     0, 0,3, 0,3, 1, 0,0, 0,0, 0,0, 1,1,9);
        step("rst_mid",   1, 0,3, 0,3, 1, 0,0, 0,0, 0,0, 0,0,0);
        step("rst_rel",   0, 0,3, 0,3, 1, 0,0, 0,0, 0,0, 0,0,0);

        @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
